seg7_scan_scheduler: RTL and testbench

//  Time-multiplexed scan scheduler for the 4-digit common-anode seven-segment display.

---
 rtl/seg7_scan_scheduler.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_scheduler.sv
// Frame-synchronous scan scheduler for a 4-digit common-anode seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_scheduler #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] number_i,
    input  logic        update_i,
    output logic        upd_ack_o,
    output logic        frame_st_o,
    output logic [6:0]  out7,
    output logic [3:0]  en_out
);

    localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    typedef enum logic [0:0] {StShow, StBlank} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap_q, wrap_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [15:0]     staging_q, staging_d;
    logic            pending_q, pending_d;
    logic [6:0]      out7_q, out7_d;
    logic [3:0]      en_q, en_d;
    logic            ack_q, ack_d;
    logic            fst_q, fst_d;
    logic [15:0]     upper;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CntW'(1);
        wrap_d    = 1'b0;
        shadow_d  = shadow_q;
        staging_d = staging_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        fst_d     = wrap_q;
        out7_d    = 7'h7F;
        en_d      = 4'hF;
        upper     = 16'h0000;

        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowLast) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        idx_d  = idx_q + 2'd1;
                        wrap_d = (idx_q == 2'd3);
                    end else begin
                        state_d = StBlank;
                    end
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    wrap_d  = (idx_q == 2'd3);
                    state_d = StShow;
                end
            end
            default: state_d = StShow;
        endcase

        // wrap_q marks the first digit-0 SHOW cycle; an update arriving then bypasses staging.
        if (wrap_q && (pending_q || update_i)) begin
            shadow_d  = update_i ? number_i : staging_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (update_i) begin
            staging_d = number_i;
            pending_d = 1'b1;
        end

        if (state_q == StShow) begin
            upper  = shadow_d >> {idx_q, 2'b00};
            out7_d = hex7(upper[3:0]);
            en_d   = ~(4'b0001 << idx_q);
`ifdef SEG7_LZB_EN
            if (idx_q != 2'd0 && upper == 16'h0000) begin
                en_d = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StShow;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            shadow_q  <= 16'h0000;
            staging_q <= 16'h0000;
            pending_q <= 1'b0;
            out7_q    <= 7'h7F;
            en_q      <= 4'hF;
            ack_q     <= 1'b0;
            fst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
            out7_q    <= out7_d;
            en_q      <= en_d;
            ack_q     <= ack_d;
            fst_q     <= fst_d;
        end
    end

    assign out7       = out7_q;
    assign en_out     = en_q;
    assign upd_ack_o  = ack_q;
    assign frame_st_o = fst_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler with PRESCALE=4, BLANK_CYCLES=2 (24-cycle frame).
// Cycle n is the output registered on the n-th rising edge after reset release (n from 0).
module tb_seg7_scan_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] number_i;
    logic        update_i;
    logic        upd_ack_o;
    logic        frame_st_o;
    logic [6:0]  out7;
    logic [3:0]  en_out;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_scheduler #(
        .PRESCALE    (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .number_i  (number_i),
        .update_i  (update_i),
        .upd_ack_o (upd_ack_o),
        .frame_st_o(frame_st_o),
        .out7      (out7),
        .en_out    (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    // Expected segments/anodes for output cycle c of a frame with committed value sh.
    task automatic expect_disp(input int c, input logic [15:0] sh,
                               output logic [6:0] e7, output logic [3:0] en);
        int pos;
        int slot;
        logic [15:0] up;
        pos  = c % 24;
        slot = pos / 6;
        e7   = 7'h7F;
        en   = 4'hF;
        if ((pos % 6) < 4) begin
            up = sh >> (4 * slot);
            e7 = hex_tbl[up[3:0]];
            en = ~(4'b0001 << slot);
`ifdef SEG7_LZB_EN
            if (slot > 0 && up == 16'h0000) en = 4'hF;
`endif
        end
    endtask

    task automatic step_check(input int c, input logic upd, input logic [15:0] num,
                              input logic [15:0] sh, input logic e_ack, input logic e_fs);
        logic [6:0] e7;
        logic [3:0] en;
        update_i = upd;
        number_i = num;
        @(posedge clk);
        #2;
        update_i = 1'b0;
        expect_disp(c, sh, e7, en);
        chk("out7", c, 32'(out7), 32'(e7));
        chk("en_out", c, 32'(en_out), 32'(en));
        chk("upd_ack", c, 32'(upd_ack_o), 32'(e_ack));
        chk("frame_st", c, 32'(frame_st_o), 32'(e_fs));
    endtask

    initial begin
        logic        upd;
        logic [15:0] num;
        logic [15:0] sh;

        rst_n    = 1'b0;
        update_i = 1'b0;
        number_i = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out7", 0, 32'(out7), 32'h7F);
        chk("rst_en", 0, 32'(en_out), 32'hF);
        chk("rst_ack", 0, 32'(upd_ack_o), 32'h0);
        chk("rst_fs", 0, 32'(frame_st_o), 32'h0);
        rst_n = 1'b1;

        // Commits at 24 (1234), 72 (latest of AAAA/00F0), 96 (8888 on the boundary edge).
        // 5555 at 97 stays pending and is lost to the reset below.
        for (int c = 0; c <= 110; c++) begin
            upd = (c == 1) || (c == 53) || (c == 57) || (c == 96) || (c == 97);
            num = (c == 1)  ? 16'h1234 :
                  (c == 53) ? 16'hAAAA :
                  (c == 57) ? 16'h00F0 :
                  (c == 96) ? 16'h8888 : 16'h5555;
            sh  = (c < 24) ? 16'h0000 :
                  (c < 72) ? 16'h1234 :
                  (c < 96) ? 16'h00F0 : 16'h8888;
            step_check(c, upd, num, sh, (c == 24) || (c == 72) || (c == 96),
                       (c > 0) && (c % 24 == 0));
        end

        rst_n = 1'b0;
        #1;
        chk("async_out7", 110, 32'(out7), 32'h7F);
        chk("async_en", 110, 32'(en_out), 32'hF);
        chk("async_ack", 110, 32'(upd_ack_o), 32'h0);
        @(posedge clk);
        #2;
        chk("hold_en", 111, 32'(en_out), 32'hF);
        rst_n = 1'b1;

        for (int c = 0; c <= 30; c++) begin
            step_check(c, 1'b0, 16'h0000, 16'h0000, 1'b0, (c == 24));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
